// File: rtl/int_rs_age_if.sv
// Dispatch, CDB wakeup and issue signals of the age-ordered integer reservation station.
// The RS side uses the slave modport; the producer/consumer side uses master.
interface int_rs_age_if #(
  parameter int CDB_WIDTH = 2,
  parameter int PRF_IDX   = 6,
  parameter int ROB_IDX   = 5,
  parameter int PAYLOAD_W = 96
) ();
  logic                           disp_valid;
  logic                           disp_ready;
  logic [PAYLOAD_W-1:0]           disp_payload;
  logic [ROB_IDX-1:0]             disp_rob_id;
  logic [2*PRF_IDX-1:0]           disp_src_phy;
  logic [1:0]                     disp_src_rdy;
  logic [CDB_WIDTH-1:0]           cdb_valid;
  logic [CDB_WIDTH*PRF_IDX-1:0]   cdb_rd_phy;
  logic                           iss_valid;
  logic                           iss_ready;
  logic [PAYLOAD_W-1:0]           iss_payload;
  logic [ROB_IDX-1:0]             iss_rob_id;
  logic [2*PRF_IDX-1:0]           iss_src_phy;

  modport master (
    output disp_valid, disp_payload, disp_rob_id, disp_src_phy, disp_src_rdy,
    output cdb_valid, cdb_rd_phy, iss_ready,
    input  disp_ready, iss_valid, iss_payload, iss_rob_id, iss_src_phy
  );

  modport slave (
    input  disp_valid, disp_payload, disp_rob_id, disp_src_phy, disp_src_rdy,
    input  cdb_valid, cdb_rd_phy, iss_ready,
    output disp_ready, iss_valid, iss_payload, iss_rob_id, iss_src_phy
  );
endinterface

// File: rtl/int_rs_age.sv
// Age-ordered integer reservation station: holds renamed uops, wakes sources from the CDB
// and issues the oldest fully-ready entry to the INT issue stage.
module int_rs_age #(
  parameter int DEPTH     = 8,
  parameter int CDB_WIDTH = 2,
  parameter int PRF_IDX   = 6,
  parameter int ROB_IDX   = 5,
  parameter int PAYLOAD_W = 96,
  localparam int OCC_W    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  int_rs_age_if.slave      bus,
  output logic [OCC_W-1:0] occupancy
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Tag 0 is the hard-wired ready register; otherwise any valid CDB channel with a matching tag wakes it.
  function automatic logic tag_woken(
    input logic [PRF_IDX-1:0]           tag,
    input logic [CDB_WIDTH-1:0]         cdb_v,
    input logic [CDB_WIDTH*PRF_IDX-1:0] cdb_t
  );
    logic hit;
    hit = (tag == {PRF_IDX{1'b0}});
    for (int k = 0; k < CDB_WIDTH; k++) begin
      hit = hit | (cdb_v[k] & (cdb_t[k*PRF_IDX +: PRF_IDX] == tag));
    end
    return hit;
  endfunction

  logic [DEPTH-1:0]         valid_q, valid_d;
  logic [DEPTH-1:0]         age_q     [DEPTH];
  logic [DEPTH-1:0]         age_d     [DEPTH];
  logic [1:0]               rdy_q     [DEPTH];
  logic [1:0]               rdy_d     [DEPTH];
  logic [2*PRF_IDX-1:0]     src_q     [DEPTH];
  logic [2*PRF_IDX-1:0]     src_d     [DEPTH];
  logic [ROB_IDX-1:0]       rob_q     [DEPTH];
  logic [ROB_IDX-1:0]       rob_d     [DEPTH];
  logic [PAYLOAD_W-1:0]     payload_q [DEPTH];
  logic [PAYLOAD_W-1:0]     payload_d [DEPTH];
  logic [OCC_W-1:0]         occ_q, occ_d;

  logic [1:0]               src_now   [DEPTH];
  logic [DEPTH-1:0]         cand;
  logic [DEPTH-1:0]         sel_oh;
  logic [IDX_W-1:0]         sel_idx;
  logic [IDX_W-1:0]         free_idx;
  logic [1:0]               disp_woken;
  logic                     accept;
  logic                     issue_fire;

  assign occupancy      = occ_q;
  assign bus.disp_ready = (occ_q != OCC_W'(DEPTH));
  assign accept         = bus.disp_valid & bus.disp_ready & ~flush;
  assign bus.iss_valid  = (|cand) & ~flush;
  assign issue_fire     = bus.iss_valid & bus.iss_ready;

  // Source readiness including same-cycle CDB bypass, and the resulting issue candidates.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      src_now[i][0] = rdy_q[i][0] | tag_woken(src_q[i][PRF_IDX-1:0], bus.cdb_valid, bus.cdb_rd_phy);
      src_now[i][1] = rdy_q[i][1] | tag_woken(src_q[i][2*PRF_IDX-1:PRF_IDX], bus.cdb_valid, bus.cdb_rd_phy);
      cand[i]       = valid_q[i] & src_now[i][0] & src_now[i][1];
    end
    disp_woken[0] = tag_woken(bus.disp_src_phy[PRF_IDX-1:0], bus.cdb_valid, bus.cdb_rd_phy);
    disp_woken[1] = tag_woken(bus.disp_src_phy[2*PRF_IDX-1:PRF_IDX], bus.cdb_valid, bus.cdb_rd_phy);
  end

  // Oldest-candidate select: age_q[j][i]=1 means entry j is older than entry i.
  always_comb begin
    sel_oh = '0;
    for (int i = 0; i < DEPTH; i++) begin
      sel_oh[i] = cand[i];
      for (int j = 0; j < DEPTH; j++) begin
        sel_oh[i] = sel_oh[i] & ~(cand[j] & age_q[j][i] & (j != i));
      end
    end
  end

  // Encode the selected and the lowest free slot, and drive the issue fields from the one-hot select.
  always_comb begin
    sel_idx         = '0;
    free_idx        = '0;
    bus.iss_payload = '0;
    bus.iss_rob_id  = '0;
    bus.iss_src_phy = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      free_idx = valid_q[i] ? free_idx : IDX_W'(i);
    end
    for (int i = 0; i < DEPTH; i++) begin
      sel_idx         = sel_oh[i] ? IDX_W'(i) : sel_idx;
      bus.iss_payload = bus.iss_payload | ({PAYLOAD_W{sel_oh[i]}} & payload_q[i]);
      bus.iss_rob_id  = bus.iss_rob_id  | ({ROB_IDX{sel_oh[i]}} & rob_q[i]);
      bus.iss_src_phy = bus.iss_src_phy | ({(2*PRF_IDX){sel_oh[i]}} & src_q[i]);
    end
  end

  // Next state: wakeup, issue invalidation, dispatch write with age update, flush.
  always_comb begin
    valid_d   = valid_q;
    age_d     = age_q;
    src_d     = src_q;
    rob_d     = rob_q;
    payload_d = payload_q;
    for (int i = 0; i < DEPTH; i++) begin
      rdy_d[i] = src_now[i];
    end

    if (flush) begin
      valid_d = '0;
    end else begin
      if (issue_fire) begin
        valid_d[sel_idx] = 1'b0;
      end else begin
        valid_d = valid_d;
      end
      if (accept) begin
        valid_d[free_idx]   = 1'b1;
        payload_d[free_idx] = bus.disp_payload;
        rob_d[free_idx]     = bus.disp_rob_id;
        src_d[free_idx]     = bus.disp_src_phy;
        rdy_d[free_idx]     = bus.disp_src_rdy | disp_woken;
        // New entry is younger than everything currently valid; its own row is cleared last.
        for (int j = 0; j < DEPTH; j++) begin
          age_d[j][free_idx] = valid_q[j];
        end
        age_d[free_idx] = '0;
      end else begin
        age_d = age_d;
      end
    end

    case ({accept, issue_fire})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: occ_d = occ_q;
    endcase
    if (flush) begin
      occ_d = '0;
    end else begin
      occ_d = occ_d;
    end
  end

  // Control state: valid bits, age matrix and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      occ_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        age_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      occ_q   <= occ_d;
      age_q   <= age_d;
    end
  end

  // Entry payload storage; meaningful only where the valid bit is set.
  always_ff @(posedge clk) begin
    rdy_q     <= rdy_d;
    src_q     <= src_d;
    rob_q     <= rob_d;
    payload_q <= payload_d;
  end

endmodule

// File: tb/tb_int_rs_age.sv
// Directed bench for int_rs_age: ordering, CDB bypass and capture, full/empty, back-pressure, flush.
module tb_int_rs_age;
  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic [3:0] occupancy;
  int         errors = 0;
  int         checks = 0;

  int_rs_age_if bus ();

  int_rs_age dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .bus       (bus),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [95:0] pl(input int rob);
    return {8'(rob), 80'h5A5A_C3C3_0F0F_9696_A5A5, ~8'(rob)};
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic chk(input string tag, input logic exp_v, input int exp_rob, input int exp_occ);
    check({tag, ".iss_valid"}, 128'(bus.iss_valid), 128'(exp_v));
    if (exp_v) check({tag, ".iss_rob"}, 128'(bus.iss_rob_id), 128'(exp_rob));
    check({tag, ".occ"}, 128'(occupancy), 128'(exp_occ));
  endtask

  task automatic disp(input logic v, input int rob, input logic [5:0] s2, input logic [5:0] s1,
                      input logic [1:0] rdy);
    bus.disp_valid   = v;
    bus.disp_rob_id  = 5'(rob);
    bus.disp_payload = pl(rob);
    bus.disp_src_phy = {s2, s1};
    bus.disp_src_rdy = rdy;
  endtask

  task automatic cdb(input logic [1:0] v, input logic [5:0] t1, input logic [5:0] t0);
    bus.cdb_valid  = v;
    bus.cdb_rd_phy = {t1, t0};
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    bus.iss_ready = 1'b0;
    disp(1'b0, 0, 6'd0, 6'd0, 2'b00);
    cdb(2'b00, 6'd0, 6'd0);
    tick();
    tick();
    rst = 1'b0;
    settle();
    chk("reset", 1'b0, 0, 0);
    check("reset.disp_ready", 128'(bus.disp_ready), 128'(1'b1));

    // Three ready uops, issue stage always accepting.
    bus.iss_ready = 1'b1;
    disp(1'b1, 1, 6'd2, 6'd1, 2'b11); settle(); chk("t1c0", 1'b0, 0, 0); tick();
    disp(1'b1, 2, 6'd2, 6'd1, 2'b11); settle(); chk("t1c1", 1'b1, 1, 1);
    check("t1c1.payload", 128'(bus.iss_payload), 128'(pl(1))); tick();
    disp(1'b1, 3, 6'd2, 6'd1, 2'b11); settle(); chk("t1c2", 1'b1, 2, 1); tick();
    disp(1'b0, 0, 6'd0, 6'd0, 2'b00); settle(); chk("t1c3", 1'b1, 3, 1); tick();
    settle(); chk("t1c4", 1'b0, 0, 0);

    // rob4 waits on tag 9 (src2 is tag 0, flagged not ready); rob5 ready; CDB wakes rob4 with bypass.
    disp(1'b1, 4, 6'd0, 6'd9, 2'b00); settle(); chk("t2c0", 1'b0, 0, 0); tick();
    disp(1'b1, 5, 6'd3, 6'd4, 2'b11); settle(); chk("t2c1", 1'b0, 0, 1); tick();
    disp(1'b0, 0, 6'd0, 6'd0, 2'b00); settle(); chk("t2c2", 1'b1, 5, 2); tick();
    cdb(2'b01, 6'd0, 6'd9); settle(); chk("t2c3", 1'b1, 4, 1);
    check("t2c3.src_phy", 128'(bus.iss_src_phy), 128'({6'd0, 6'd9}));
    check("t2c3.payload", 128'(bus.iss_payload), 128'(pl(4))); tick();
    cdb(2'b00, 6'd0, 6'd0); settle(); chk("t2c4", 1'b0, 0, 0);

    // Dispatch-cycle CDB match on channel 1 must be captured.
    disp(1'b1, 6, 6'd0, 6'd12, 2'b10); cdb(2'b10, 6'd12, 6'd0); settle(); chk("t3c0", 1'b0, 0, 0); tick();
    disp(1'b0, 0, 6'd0, 6'd0, 2'b00); cdb(2'b00, 6'd0, 6'd0); settle(); chk("t3c1", 1'b1, 6, 1); tick();
    settle(); chk("t3c2", 1'b0, 0, 0);

    // Fill all entries with waiting uops.
    for (int i = 0; i < 8; i++) begin
      disp(1'b1, 8 + i, 6'd0, 6'(20 + i), 2'b10);
      settle();
      check("t4.fill_ready", 128'(bus.disp_ready), 128'(1'b1));
      tick();
    end
    disp(1'b0, 0, 6'd0, 6'd0, 2'b00); cdb(2'b10, 6'd40, 6'd0); settle();
    chk("t4.full", 1'b0, 0, 8);
    check("t4.full.disp_ready", 128'(bus.disp_ready), 128'(1'b0)); tick();
    disp(1'b1, 30, 6'd0, 6'd0, 2'b11); cdb(2'b01, 6'd0, 6'd22); settle();
    chk("t4.release", 1'b1, 10, 8);
    check("t4.release.disp_ready", 128'(bus.disp_ready), 128'(1'b0)); tick();
    disp(1'b0, 0, 6'd0, 6'd0, 2'b00); cdb(2'b00, 6'd0, 6'd0); settle();
    chk("t4.after", 1'b0, 0, 7);
    check("t4.after.disp_ready", 128'(bus.disp_ready), 128'(1'b1));
    flush = 1'b1; tick();
    flush = 1'b0; settle(); chk("t4.flushed", 1'b0, 0, 0);

    // Back-pressure; rob19 lands in slot 0 but is youngest.
    bus.iss_ready = 1'b0;
    disp(1'b1, 16, 6'd1, 6'd1, 2'b11); settle(); chk("t5c0", 1'b0, 0, 0); tick();
    disp(1'b1, 17, 6'd1, 6'd1, 2'b11); settle(); chk("t5c1", 1'b1, 16, 1); tick();
    disp(1'b1, 18, 6'd1, 6'd1, 2'b11); bus.iss_ready = 1'b1; settle(); chk("t5c2", 1'b1, 16, 2); tick();
    disp(1'b0, 0, 6'd0, 6'd0, 2'b00); bus.iss_ready = 1'b0; settle(); chk("t5c3", 1'b1, 17, 2); tick();
    disp(1'b1, 19, 6'd1, 6'd1, 2'b11); settle(); chk("t5c4", 1'b1, 17, 2); tick();
    disp(1'b0, 0, 6'd0, 6'd0, 2'b00);
    for (int i = 0; i < 4; i++) begin
      settle(); chk("t5.hold", 1'b1, 17, 3); tick();
    end
    bus.iss_ready = 1'b1;
    settle(); chk("t5.d0", 1'b1, 17, 3); tick();
    settle(); chk("t5.d1", 1'b1, 18, 2); tick();
    settle(); chk("t5.d2", 1'b1, 19, 1); tick();
    settle(); chk("t5.d3", 1'b0, 0, 0);

    // Flush with five ready entries and a concurrent dispatch.
    bus.iss_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      disp(1'b1, 20 + i, 6'd1, 6'd1, 2'b11);
      tick();
    end
    disp(1'b1, 25, 6'd1, 6'd1, 2'b11); flush = 1'b1; bus.iss_ready = 1'b1; settle();
    chk("t6.flush", 1'b0, 0, 5); tick();
    disp(1'b0, 0, 6'd0, 6'd0, 2'b00); flush = 1'b0; settle();
    chk("t6.after", 1'b0, 0, 0);
    check("t6.after.disp_ready", 128'(bus.disp_ready), 128'(1'b1)); tick();
    settle(); chk("t6.settled", 1'b0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
